hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the non-forwarding 5-stage core. Owns stall/flush of PC, IF/ID, ID/EX,
//  EX/MEM and MEM/WB. Tracks in-flight register writes in a per-register scoreboard, stalls ID on
//  RAW hazards, squashes wrong-path instructions on EX redirect and freezes the pipe on data-memory wait.
// PARAMETERS
//  CNT_W      2  width of each per-register pending-write counter (max 3 in flight: ID/EX, EX/MEM, MEM/WB)
//  WB_BYPASS  0  1 = regfile writes through in WB, so a hazard retiring this cycle is not a stall
// PORTS
//  i_clk           in   1   clock
//  i_reset         in   1   async active-low reset
//  i_id_vld        in   1   ID stage holds a valid instruction
//  i_id_rs1_addr   in   5   ID source 1
//  i_id_rs1_used   in   1   ID instruction reads rs1
//  i_id_rs2_addr   in   5   ID source 2
//  i_id_rs2_used   in   1   ID instruction reads rs2
//  i_id_rd_addr    in   5   ID destination
//  i_id_rd_wren    in   1   ID instruction writes rd
//  i_ex_vld        in   1   EX stage holds a valid instruction
//  i_ex_pc_sel     in   1   EX redirect (taken branch/jump)
//  i_wb_vld        in   1   WB stage holds a valid instruction
//  i_wb_rd_addr    in   5   WB destination
//  i_wb_rd_wren    in   1   WB writes rd this cycle
//  i_mem_wait      in   1   data memory not ready; MEM must hold
//  o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem       out 1 each  hold stage
//  o_flush_if_id, o_flush_id_ex, o_flush_mem_wb                   out 1 each  load bubble
//  o_busy_mask     out  32  bit r = scoreboard count[r] != 0 (bit 0 always 0)
//  o_stall_cycles  out  32  saturating count of cycles with RAW or memory stall
//  o_flush_events  out  32  saturating count of accepted redirects
//  o_sb_err        out  1   sticky: counter overflow or underflow attempted
// BEHAVIOUR
//  Reset: all counters, perf counters, o_sb_err = 0; stall/flush outputs forced 0 while i_reset low.
//  Stall/flush outputs are combinational from state + inputs (same cycle); state updates on posedge.
//  redirect = i_ex_vld & i_ex_pc_sel.
//  raw = i_id_vld & ((rs1_used & rs1!=0 & pend(rs1)) | (rs2_used & rs2!=0 & pend(rs2))),
//    pend(r) = count[r]!=0, except WB_BYPASS=1: count[r]==1 & wb retiring r this cycle -> not pending.
//  Priority (highest first):
//   1 i_mem_wait: stall PC, IF/ID, ID/EX, EX/MEM; flush MEM/WB. redirect/raw ignored (re-presented later).
//   2 redirect: flush IF/ID, ID/EX; no stall (PC loads target). raw ignored (ID instruction squashed).
//   3 raw: stall PC, IF/ID; flush ID/EX (bubble). EX/MEM, MEM/WB advance.
//   4 none: all 0.
//  Issue = i_id_vld & !i_mem_wait & !redirect & !raw. Issue & rd_wren & rd!=0 -> count[rd] +1.
//  Retire = i_wb_vld & i_wb_rd_wren & rd!=0 -> count[rd] -1 (retire occurs even under mem_wait).
//  Same-cycle issue and retire to same rd: count unchanged. x0 never tracked.
//  Increment at max or decrement at 0: count saturates/holds, o_sb_err set until reset.
//  o_stall_cycles +1 when case 1 or 3 active; o_flush_events +1 when case 2 active; both stop at 2^32-1.
//  Reset mid-operation: all state cleared immediately (async); pipeline regs reset in parallel.
// STRUCTURE
//  hazard_pkg: CNT_W default, enum for priority case {HZ_NONE, HZ_RAW, HZ_REDIRECT, HZ_MEMWAIT}.
//  Sub-module reg_scoreboard: 31 counters, inc/dec ports, pend lookup x2 with bypass, busy mask, error.
//  hazard_ctrl: priority decode, output mapping, perf counters.
// TESTING
//  issue addi x5 (rd_wren) then next ID reads x5 -> stall_pc/if_id=1, flush_id_ex=1 for 3 cycles; busy_mask[5] 1->0.
//  same with WB_BYPASS=1 -> stall for 2 cycles only; o_stall_cycles=2.
//  two writes to x7 back-to-back -> count[7]=2; after first WB busy_mask[7] stays 1; after second =0.
//  raw on x5 + i_ex_vld&i_ex_pc_sel same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0, no x5 increment.
//  i_mem_wait 4 cycles during redirect -> stalls 1..4, flush_mem_wb=1, redirect flush on cycle 5, o_flush_events=1.
//  rd=x0 writes, WB retire at count 0 -> busy_mask=0, o_sb_err 0 then 1; reset low mid-stall -> all outputs 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller and its register scoreboard.
package hazard_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 2;
    localparam int unsigned NUM_REGS  = 32;

    // Active pipeline-control case, highest priority last.
    typedef enum logic [1:0] {
        HzNone,
        HzRaw,
        HzRedirect,
        HzMemwait
    } hz_case_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val);
        return (val == 32'hffff_ffff) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX/WB status in, stall/flush/status out.
interface hazard_ctrl_if;

    logic        i_id_vld;
    logic [4:0]  i_id_rs1_addr;
    logic        i_id_rs1_used;
    logic [4:0]  i_id_rs2_addr;
    logic        i_id_rs2_used;
    logic [4:0]  i_id_rd_addr;
    logic        i_id_rd_wren;
    logic        i_ex_vld;
    logic        i_ex_pc_sel;
    logic        i_wb_vld;
    logic [4:0]  i_wb_rd_addr;
    logic        i_wb_rd_wren;
    logic        i_mem_wait;

    logic        o_stall_pc;
    logic        o_stall_if_id;
    logic        o_stall_id_ex;
    logic        o_stall_ex_mem;
    logic        o_flush_if_id;
    logic        o_flush_id_ex;
    logic        o_flush_mem_wb;
    logic [31:0] o_busy_mask;
    logic [31:0] o_stall_cycles;
    logic [31:0] o_flush_events;
    logic        o_sb_err;

    modport master (
        output i_id_vld, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_ex_vld, i_ex_pc_sel, i_wb_vld,
               i_wb_rd_addr, i_wb_rd_wren, i_mem_wait,
        input  o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_flush_if_id,
               o_flush_id_ex, o_flush_mem_wb, o_busy_mask, o_stall_cycles, o_flush_events,
               o_sb_err
    );

    modport slave (
        input  i_id_vld, i_id_rs1_addr, i_id_rs1_used, i_id_rs2_addr, i_id_rs2_used,
               i_id_rd_addr, i_id_rd_wren, i_ex_vld, i_ex_pc_sel, i_wb_vld,
               i_wb_rd_addr, i_wb_rd_wren, i_mem_wait,
        output o_stall_pc, o_stall_if_id, o_stall_id_ex, o_stall_ex_mem, o_flush_if_id,
               o_flush_id_ex, o_flush_mem_wb, o_busy_mask, o_stall_cycles, o_flush_events,
               o_sb_err
    );

endinterface

// File: rtl/hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write counters with two source lookups and optional WB bypass.
module hazard_ctrl_reg_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_inc_en,
    input  logic [4:0]  i_inc_addr,
    input  logic        i_dec_en,
    input  logic [4:0]  i_dec_addr,
    input  logic [4:0]  i_rs1_addr,
    input  logic [4:0]  i_rs2_addr,
    output logic        o_rs1_pend,
    output logic        o_rs2_pend,
    output logic [31:0] o_busy_mask,
    output logic        o_err
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q, err_d;
    logic             inc_hit, dec_hit;

    always_comb begin
        err_d   = err_q;
        inc_hit = 1'b0;
        dec_hit = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            inc_hit  = i_inc_en && (i_inc_addr == 5'(r));
            dec_hit  = i_dec_en && (i_dec_addr == 5'(r));
            // Simultaneous issue and retire to one register cancel out.
            if (inc_hit && !dec_hit) begin
                if (cnt_q[r] == CntMax) err_d = 1'b1;
                else                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_hit && !inc_hit) begin
                if (cnt_q[r] == '0) err_d = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
            err_q <= err_d;
        end
    end

    always_comb begin
        o_busy_mask = '0;
        for (int r = 1; r < NUM_REGS; r++) o_busy_mask[r] = (cnt_q[r] != '0);
    end

    // With bypass, the last outstanding write retiring this cycle is already visible.
    always_comb begin
        o_rs1_pend = (i_rs1_addr != 5'd0) && (cnt_q[i_rs1_addr] != '0) &&
                     !(WB_BYPASS && (cnt_q[i_rs1_addr] == CNT_W'(1)) &&
                       i_dec_en && (i_dec_addr == i_rs1_addr));
        o_rs2_pend = (i_rs2_addr != 5'd0) && (cnt_q[i_rs2_addr] != '0) &&
                     !(WB_BYPASS && (cnt_q[i_rs2_addr] == CNT_W'(1)) &&
                       i_dec_en && (i_dec_addr == i_rs2_addr));
    end

    assign o_err = err_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the non-forwarding 5-stage pipeline, with perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    hazard_ctrl_if.slave bus
);

    logic     rs1_pend, rs2_pend;
    logic     redirect, raw, issue;
    logic     inc_en, dec_en;
    hz_case_e hz;
    logic     busy_err;
    logic [31:0] busy_mask;
    logic [31:0] stall_cycles_q, flush_events_q;

    assign redirect = bus.i_ex_vld & bus.i_ex_pc_sel;
    assign raw      = bus.i_id_vld & ((bus.i_id_rs1_used & rs1_pend) |
                                      (bus.i_id_rs2_used & rs2_pend));

    always_comb begin
        if (bus.i_mem_wait)  hz = HzMemwait;
        else if (redirect)   hz = HzRedirect;
        else if (raw)        hz = HzRaw;
        else                 hz = HzNone;
    end

    assign issue  = bus.i_id_vld & (hz == HzNone);
    assign inc_en = issue & bus.i_id_rd_wren & (bus.i_id_rd_addr != 5'd0);
    assign dec_en = bus.i_wb_vld & bus.i_wb_rd_wren & (bus.i_wb_rd_addr != 5'd0);

    hazard_ctrl_reg_scoreboard #(
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_inc_en    (inc_en),
        .i_inc_addr  (bus.i_id_rd_addr),
        .i_dec_en    (dec_en),
        .i_dec_addr  (bus.i_wb_rd_addr),
        .i_rs1_addr  (bus.i_id_rs1_addr),
        .i_rs2_addr  (bus.i_id_rs2_addr),
        .o_rs1_pend  (rs1_pend),
        .o_rs2_pend  (rs2_pend),
        .o_busy_mask (busy_mask),
        .o_err       (busy_err)
    );

    // Control outputs are held low while reset is asserted.
    always_comb begin
        bus.o_stall_pc     = 1'b0;
        bus.o_stall_if_id  = 1'b0;
        bus.o_stall_id_ex  = 1'b0;
        bus.o_stall_ex_mem = 1'b0;
        bus.o_flush_if_id  = 1'b0;
        bus.o_flush_id_ex  = 1'b0;
        bus.o_flush_mem_wb = 1'b0;
        if (i_reset) begin
            unique case (hz)
                HzMemwait: begin
                    bus.o_stall_pc     = 1'b1;
                    bus.o_stall_if_id  = 1'b1;
                    bus.o_stall_id_ex  = 1'b1;
                    bus.o_stall_ex_mem = 1'b1;
                    bus.o_flush_mem_wb = 1'b1;
                end
                HzRedirect: begin
                    bus.o_flush_if_id = 1'b1;
                    bus.o_flush_id_ex = 1'b1;
                end
                HzRaw: begin
                    bus.o_stall_pc    = 1'b1;
                    bus.o_stall_if_id = 1'b1;
                    bus.o_flush_id_ex = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if ((hz == HzMemwait) || (hz == HzRaw)) stall_cycles_q <= sat_inc32(stall_cycles_q);
            if (hz == HzRedirect)                   flush_events_q <= sat_inc32(flush_events_q);
        end
    end

    assign bus.o_busy_mask    = busy_mask;
    assign bus.o_stall_cycles = stall_cycles_q;
    assign bus.o_flush_events = flush_events_q;
    assign bus.o_sb_err       = busy_err;

endmodule
